mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the data and address width.
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 ex_writeaddr_i  input  5  SHALL be the destination register from EX.
REQ-005 ex_wb_i  input  2  SHALL be the WB control from EX: bit0 RegWrite, bit1 MemtoReg.
REQ-006 ex_memrd_i / ex_memwr_i  input  1 each  SHALL be the load / store strobes from EX.
REQ-007 ex_alures_i / ex_wdata_i  input  DATA_W each  SHALL be the ALU result (address) and the store data from EX.
REQ-008 dcache_req_o / dcache_we_o  output  1 each  SHALL be the data-cache request and write-enable.
REQ-009 dcache_addr_o / dcache_wdata_o  output  DATA_W each  SHALL be the data-cache address and write data.
REQ-010 dcache_ack_i  input  1 and dcache_rdata_i  input  DATA_W  SHALL be the cache completion and read data.
REQ-011 stall_o  output  1  SHALL freeze every upstream stage while high.
REQ-012 exmem_writeaddr_o  output  5, exmem_wb_o  output  2, exmem_alures_o  output  DATA_W  SHALL expose the EX/MEM register to the forwarding unit and its mux.
REQ-013 memwb_writeaddr_o  output  5, memwb_wb_o  output  1, memwb_data_o  output  DATA_W  SHALL expose the MEM/WB register: RegWrite plus the selected write-back data.

Function
REQ-014 The EX/MEM register SHALL capture all ex_* inputs on every edge where stall_o=0 and SHALL hold them while stall_o=1.
REQ-015 mem_op is defined as EX/MEM memrd OR memwr; dcache_req_o SHALL equal mem_op AND NOT done_q.
REQ-016 dcache_we_o SHALL equal the EX/MEM memwr bit; dcache_addr_o and dcache_wdata_o SHALL be driven straight from EX/MEM.
REQ-017 stall_o SHALL equal dcache_req_o AND NOT dcache_ack_i; a same-cycle ack (hit) costs zero stall cycles.
REQ-018 The FSM SHALL have exactly two states, IDLE and WAIT.
REQ-019 The FSM SHALL go IDLE->WAIT when dcache_req_o=1 and ack=0, stay in WAIT while ack=0, and go WAIT->IDLE on ack=1.
REQ-020 done_q SHALL never be set in the base design (reserved for REQ-031) and SHALL be cleared whenever EX/MEM loads.
REQ-021 The MEM/WB register SHALL load on every edge where stall_o=0 and hold while stall_o=1.
REQ-022 On load, memwb_data_o SHALL take dcache_rdata_i when EX/MEM wb bit1=1 (MemtoReg), otherwise EX/MEM alures.
REQ-023 On load, memwb_wb_o SHALL take EX/MEM wb bit0 and memwb_writeaddr_o SHALL take EX/MEM writeaddr.
REQ-024 An ack arriving while dcache_req_o=0 SHALL be ignored.
REQ-025 Back-to-back memory ops SHALL each issue exactly one request; a second op follows the first with no idle bubble.
REQ-026 A store SHALL write MEM/WB with RegWrite as supplied; no special-casing is done.

Reset
REQ-027 While rst_i=1, all EX/MEM and MEM/WB fields, done_q and err_o SHALL be 0 and the FSM SHALL be IDLE.
REQ-028 Consequently dcache_req_o=0 and stall_o=0 during reset; assertion mid-WAIT SHALL abandon the access with no write-back.

Configuration
REQ-029 Macro MEM_STAGE_WDT_EN SHALL enable an 8-bit watchdog counter and output err_o (1 bit).
REQ-030 With the macro, the counter SHALL clear in IDLE, increment each WAIT cycle, and on reaching 255 SHALL set sticky err_o, set done_q, and force the FSM to IDLE.
REQ-031 While done_q=1, MEM/WB data SHALL be loaded as 0 and stall_o SHALL be 0.
REQ-032 Without the macro, neither err_o nor the counter SHALL exist, and WAIT SHALL last until ack.

Structure
REQ-033 The FSM state encoding, the WB bit indices (REGWRITE=0, MEMTOREG=1) and the watchdog limit 255 SHALL live in a shared pipeline package.
REQ-034 One sub-module, mem_stage_fsm (IDLE/WAIT, done_q, watchdog), SHALL be instantiated; the pipeline registers stay in mem_stage.

Verification
REQ-035 A load to addr 0x10 with ack in the same cycle, rdata 0xDEADBEEF, wb=2'b11, rd=5 SHALL give stall_o=0 and, after one edge, memwb_data_o=0xDEADBEEF, memwb_wb_o=1, memwb_writeaddr_o=5.
REQ-036 A store with ack delayed 3 cycles SHALL hold stall_o=1 for exactly 3 cycles, keep dcache_req_o=1 and we=1 throughout, and keep EX/MEM unchanged.
REQ-037 An ALU op (wb=2'b01, alures=0x1234, rd=7) SHALL give dcache_req_o=0 and, after one edge, memwb_data_o=0x1234.
REQ-038 Two back-to-back loads, each with a 1-cycle ack delay, SHALL produce exactly two req episodes and a total of 2 stall cycles.
REQ-039 Asserting rst_i in WAIT SHALL zero all outputs asynchronously, with no MEM/WB write.
REQ-040 With MEM_STAGE_WDT_EN and ack never asserted, err_o SHALL rise after 255 WAIT cycles and stall_o SHALL drop on the next cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: FSM states, WB control bit
// positions and the data-cache watchdog limit.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } memState_e;

  localparam int unsigned WB_REGWRITE = 0;
  localparam int unsigned WB_MEMTOREG = 1;

  localparam logic [7:0] WDT_LIMIT = 8'd255;

endpackage

// File: rtl/mem_stage_fsm.sv
// Data-cache access tracker for the MEM stage (IDLE/WAIT, done flag).
// With MEM_STAGE_WDT_EN defined, a watchdog abandons accesses that never ack.
module mem_stage_fsm
  import mem_stage_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic ack_i,
  input  logic load_i,
  output logic done_o
`ifdef MEM_STAGE_WDT_EN
  ,
  output logic err_o
`endif
);

  memState_e state_q, state_d;
  logic      done_q;
  logic      wdtFire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_i && !ack_i) state_d = WAIT;
      WAIT:    if (ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wdtFire) state_d = IDLE;
  end

  // A fired watchdog retires the stuck access; the next EX/MEM load clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q <= 1'b0;
    end else if (wdtFire) begin
      done_q <= 1'b1;
    end else if (load_i) begin
      done_q <= 1'b0;
    end
  end

  assign done_o = done_q;

`ifdef MEM_STAGE_WDT_EN
  logic [7:0] wdtCnt_q, wdtCnt_d;
  logic       err_q;

  assign wdtFire  = (state_q == WAIT) && !ack_i && (wdtCnt_q == WDT_LIMIT - 8'd1);
  assign wdtCnt_d = (state_q == WAIT) ? wdtCnt_q + 8'd1 : 8'd0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdtCnt_q <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      wdtCnt_q <= wdtCnt_d;
      err_q    <= err_q | wdtFire;
    end
  end

  assign err_o = err_q;
`else
  assign wdtFire = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers around a data-cache port.
// Optional watchdog (err_o) is enabled by defining MEM_STAGE_WDT_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        ex_writeaddr_i,
  input  logic [1:0]        ex_wb_i,
  input  logic              ex_memrd_i,
  input  logic              ex_memwr_i,
  input  logic [DATA_W-1:0] ex_alures_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  output logic              dcache_req_o,
  output logic              dcache_we_o,
  output logic [DATA_W-1:0] dcache_addr_o,
  output logic [DATA_W-1:0] dcache_wdata_o,
  input  logic              dcache_ack_i,
  input  logic [DATA_W-1:0] dcache_rdata_i,
  output logic              stall_o,
  output logic [4:0]        exmem_writeaddr_o,
  output logic [1:0]        exmem_wb_o,
  output logic [DATA_W-1:0] exmem_alures_o,
  output logic [4:0]        memwb_writeaddr_o,
  output logic              memwb_wb_o,
  output logic [DATA_W-1:0] memwb_data_o
`ifdef MEM_STAGE_WDT_EN
  ,
  output logic              err_o
`endif
);

  logic [4:0]        exMemWriteAddr_q;
  logic [1:0]        exMemWb_q;
  logic              exMemMemRd_q;
  logic              exMemMemWr_q;
  logic [DATA_W-1:0] exMemAlures_q;
  logic [DATA_W-1:0] exMemWdata_q;

  logic [4:0]        memWbWriteAddr_q;
  logic              memWbRegWrite_q;
  logic [DATA_W-1:0] memWbData_q, memWbData_d;

  logic memOp;
  logic done;
  logic stall;

  assign memOp        = exMemMemRd_q | exMemMemWr_q;
  assign dcache_req_o = memOp & ~done;
  assign stall        = dcache_req_o & ~dcache_ack_i;
  assign stall_o      = stall;

  mem_stage_fsm u_fsm (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (dcache_req_o),
    .ack_i  (dcache_ack_i),
    .load_i (~stall),
    .done_o (done)
`ifdef MEM_STAGE_WDT_EN
    ,
    .err_o  (err_o)
`endif
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exMemWriteAddr_q <= '0;
      exMemWb_q        <= '0;
      exMemMemRd_q     <= 1'b0;
      exMemMemWr_q     <= 1'b0;
      exMemAlures_q    <= '0;
      exMemWdata_q     <= '0;
    end else if (!stall) begin
      exMemWriteAddr_q <= ex_writeaddr_i;
      exMemWb_q        <= ex_wb_i;
      exMemMemRd_q     <= ex_memrd_i;
      exMemMemWr_q     <= ex_memwr_i;
      exMemAlures_q    <= ex_alures_i;
      exMemWdata_q     <= ex_wdata_i;
    end
  end

  // An abandoned (watchdog) access writes back zero instead of stale cache data.
  always_comb begin
    memWbData_d = exMemAlures_q;
    if (done) begin
      memWbData_d = '0;
    end else if (exMemWb_q[WB_MEMTOREG]) begin
      memWbData_d = dcache_rdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      memWbWriteAddr_q <= '0;
      memWbRegWrite_q  <= 1'b0;
      memWbData_q      <= '0;
    end else if (!stall) begin
      memWbWriteAddr_q <= exMemWriteAddr_q;
      memWbRegWrite_q  <= exMemWb_q[WB_REGWRITE];
      memWbData_q      <= memWbData_d;
    end
  end

  assign dcache_we_o       = exMemMemWr_q;
  assign dcache_addr_o     = exMemAlures_q;
  assign dcache_wdata_o    = exMemWdata_q;
  assign exmem_writeaddr_o = exMemWriteAddr_q;
  assign exmem_wb_o        = exMemWb_q;
  assign exmem_alures_o    = exMemAlures_q;
  assign memwb_writeaddr_o = memWbWriteAddr_q;
  assign memwb_wb_o        = memWbRegWrite_q;
  assign memwb_data_o      = memWbData_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors, corner sequences and a
// randomized run against a cycle-level pipeline model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  exWa;
  logic [1:0]  exWb;
  logic        exRd, exWr;
  logic [31:0] exAlu, exWd;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        stall;
  logic [4:0]  xmWa;
  logic [1:0]  xmWb;
  logic [31:0] xmAlu;
  logic [4:0]  mwWa;
  logic        mwWb;
  logic [31:0] mwData;
`ifdef MEM_STAGE_WDT_EN
  logic        err;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(32)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .ex_writeaddr_i    (exWa),
    .ex_wb_i           (exWb),
    .ex_memrd_i        (exRd),
    .ex_memwr_i        (exWr),
    .ex_alures_i       (exAlu),
    .ex_wdata_i        (exWd),
    .dcache_req_o      (req),
    .dcache_we_o       (we),
    .dcache_addr_o     (addr),
    .dcache_wdata_o    (wdata),
    .dcache_ack_i      (ack),
    .dcache_rdata_i    (rdata),
    .stall_o           (stall),
    .exmem_writeaddr_o (xmWa),
    .exmem_wb_o        (xmWb),
    .exmem_alures_o    (xmAlu),
    .memwb_writeaddr_o (mwWa),
    .memwb_wb_o        (mwWb),
    .memwb_data_o      (mwData)
`ifdef MEM_STAGE_WDT_EN
    ,
    .err_o             (err)
`endif
  );

  typedef struct {
    logic [4:0]  wa;
    logic [1:0]  wb;
    logic        rd;
    logic        wr;
    logic [31:0] alu;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] rdata;
    logic        expReq;
    logic        expWe;
    logic        expStall;
    logic [31:0] expData;
    logic        expWb;
    logic [4:0]  expWa;
  } vec_t;

  vec_t vecs[7];

  task automatic applyStimulus(input logic [4:0] wa, input logic [1:0] wb, input logic rd,
                               input logic wr, input logic [31:0] alu, input logic [31:0] wd,
                               input logic a, input logic [31:0] rdat);
    exWa  = wa;
    exWb  = wb;
    exRd  = rd;
    exWr  = wr;
    exAlu = alu;
    exWd  = wd;
    ack   = a;
    rdata = rdat;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(5'd0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
    nextCycle();
  endtask

  // Cycle-level model state: pipeline register contents and forced-ack streak.
  logic [4:0]  mExWa, mWbWa;
  logic [1:0]  mExWb;
  logic        mExRd, mExWr, mWbRw, mStall;
  logic [31:0] mExAlu, mExWd, mWbData;
  int          streak;

  initial begin
    int stallCnt, reqCnt, accepts;
    logic [31:0] ra, rb;

    vecs[0] = '{5'd5,  2'b11, 1'b1, 1'b0, 32'h10,       32'h0,    1'b1, 32'hDEADBEEF,
                1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 5'd5};
    vecs[1] = '{5'd7,  2'b01, 1'b0, 1'b0, 32'h1234,     32'h0,    1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h1234,     1'b1, 5'd7};
    vecs[2] = '{5'd3,  2'b00, 1'b0, 1'b1, 32'h20,       32'hCAFE, 1'b1, 32'h5555,
                1'b1, 1'b1, 1'b0, 32'h20,       1'b0, 5'd3};
    vecs[3] = '{5'd9,  2'b01, 1'b0, 1'b0, 32'hABCD,     32'h0,    1'b1, 32'h99,
                1'b0, 1'b0, 1'b0, 32'hABCD,     1'b1, 5'd9};
    vecs[4] = '{5'd2,  2'b11, 1'b0, 1'b0, 32'h77,       32'h0,    1'b0, 32'h4242,
                1'b0, 1'b0, 1'b0, 32'h4242,     1'b1, 5'd2};
    vecs[5] = '{5'd4,  2'b01, 1'b0, 1'b1, 32'h44,       32'h1,    1'b1, 32'h0,
                1'b1, 1'b1, 1'b0, 32'h44,       1'b1, 5'd4};
    vecs[6] = '{5'd31, 2'b10, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,    1'b1, 32'h0BADF00D,
                1'b1, 1'b0, 1'b0, 32'h0BADF00D, 1'b0, 5'd31};

    // Reset state, with busy inputs present while reset is held.
    rst = 1'b1;
    applyStimulus(5'd17, 2'b11, 1'b1, 1'b1, 32'hFFFF, 32'hAAAA, 1'b1, 32'h1);
    nextCycle();
    @(negedge clk);
    checkOutput("rst_req", req, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_exmem_alu", xmAlu, 0);
    checkOutput("rst_exmem_wb", xmWb, 0);
    checkOutput("rst_memwb_data", mwData, 0);
    checkOutput("rst_memwb_wa", mwWa, 0);
`ifdef MEM_STAGE_WDT_EN
    checkOutput("rst_err", err, 0);
`endif
    nextCycle();
    rst = 1'b0;
    applyStimulus(5'd0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    nextCycle();

    $display("[TB] directed vectors");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].wa, vecs[i].wb, vecs[i].rd, vecs[i].wr, vecs[i].alu, vecs[i].wd,
                    1'b0, 32'h0);
      nextCycle();
      applyStimulus(5'd0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, vecs[i].ack, vecs[i].rdata);
      @(negedge clk);
      checkOutput($sformatf("v%0d_req", i), req, vecs[i].expReq);
      checkOutput($sformatf("v%0d_we", i), we, vecs[i].expWe);
      checkOutput($sformatf("v%0d_stall", i), stall, vecs[i].expStall);
      checkOutput($sformatf("v%0d_addr", i), addr, vecs[i].alu);
      checkOutput($sformatf("v%0d_wdata", i), wdata, vecs[i].wd);
      checkOutput($sformatf("v%0d_exmem_wa", i), xmWa, vecs[i].wa);
      checkOutput($sformatf("v%0d_exmem_wb", i), xmWb, vecs[i].wb);
      nextCycle();
      @(negedge clk);
      checkOutput($sformatf("v%0d_memwb_data", i), mwData, vecs[i].expData);
      checkOutput($sformatf("v%0d_memwb_wb", i), mwWb, vecs[i].expWb);
      checkOutput($sformatf("v%0d_memwb_wa", i), mwWa, vecs[i].expWa);
      nextCycle();
    end

    $display("[TB] store with 3-cycle ack delay");
    applyStimulus(5'd12, 2'b00, 1'b0, 1'b1, 32'h40, 32'hFEEDF00D, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(5'd1, 2'b11, 1'b1, 1'b0, 32'h99, 32'h0, 1'b0, 32'h0);
    stallCnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) ack = 1'b1;
      @(negedge clk);
      if (stall) stallCnt++;
      checkOutput($sformatf("st_req_%0d", k), req, 1);
      checkOutput($sformatf("st_we_%0d", k), we, 1);
      checkOutput($sformatf("st_exmem_alu_%0d", k), xmAlu, 32'h40);
      checkOutput($sformatf("st_wdata_%0d", k), wdata, 32'hFEEDF00D);
      nextCycle();
    end
    checkOutput("st_stall_cycles", stallCnt, 3);
    applyStimulus(5'd0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hAB);
    @(negedge clk);
    checkOutput("st_memwb_data", mwData, 32'h40);
    checkOutput("st_memwb_wa", mwWa, 12);
    checkOutput("st_memwb_wb", mwWb, 0);
    checkOutput("st_next_exmem_alu", xmAlu, 32'h99);
    nextCycle();
    @(negedge clk);
    checkOutput("st_next_memwb_data", mwData, 32'hAB);
    nextCycle();

    $display("[TB] back-to-back loads, 1-cycle ack delay each");
    ra = 32'h1111AAAA;
    rb = 32'h2222BBBB;
    applyStimulus(5'd10, 2'b11, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(5'd11, 2'b11, 1'b1, 1'b0, 32'h104, 32'h0, 1'b0, 32'h0);
    stallCnt = 0;
    reqCnt   = 0;
    accepts  = 0;
    for (int k = 0; k < 4; k++) begin
      ack   = (k % 2) == 1;
      rdata = (k == 1) ? ra : ((k == 3) ? rb : 32'h0);
      if (k == 2) begin
        exWa = 5'd0; exWb = 2'b00; exRd = 1'b0; exAlu = 32'h0;
      end
      @(negedge clk);
      if (req) reqCnt++;
      if (stall) stallCnt++;
      if (req && ack) accepts++;
      if (k == 2) checkOutput("b2b_memwb_a", mwData, ra);
      nextCycle();
    end
    checkOutput("b2b_req_cycles", reqCnt, 4);
    checkOutput("b2b_accepts", accepts, 2);
    checkOutput("b2b_stall_cycles", stallCnt, 2);
    ack = 1'b0;
    @(negedge clk);
    checkOutput("b2b_memwb_b", mwData, rb);
    checkOutput("b2b_memwb_wa", mwWa, 11);
    checkOutput("b2b_req_after", req, 0);
    nextCycle();

    $display("[TB] reset asserted during WAIT");
    applyStimulus(5'd8, 2'b01, 1'b0, 1'b0, 32'h5A5A, 32'h0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(5'd6, 2'b11, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(5'd0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h77);
    @(negedge clk);
    checkOutput("rw_stall_pre", stall, 1);
    checkOutput("rw_memwb_pre", mwData, 32'h5A5A);
    nextCycle();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rw_req", req, 0);
    checkOutput("rw_stall", stall, 0);
    checkOutput("rw_exmem_alu", xmAlu, 0);
    checkOutput("rw_memwb_data", mwData, 0);
    checkOutput("rw_memwb_wb", mwWb, 0);
    checkOutput("rw_memwb_wa", mwWa, 0);
    ack = 1'b1;
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rw_memwb_after", mwData, 0);
    nextCycle();

    $display("[TB] randomized run against model");
    resetDut();
    {mExWa, mExWb, mExRd, mExWr, mExAlu, mExWd} = '0;
    {mWbWa, mWbRw, mWbData} = '0;
    streak = 0;
    for (int c = 0; c < 400; c++) begin
      applyStimulus(5'($urandom), 2'($urandom), $urandom_range(0, 2) == 0,
                    $urandom_range(0, 2) == 0, $urandom, $urandom,
                    (streak >= 5) ? 1'b1 : 1'($urandom), $urandom);
      mStall = (mExRd | mExWr) & ~ack;
      @(negedge clk);
      checkOutput("rnd_req", req, mExRd | mExWr);
      checkOutput("rnd_we", we, mExWr);
      checkOutput("rnd_addr", addr, mExAlu);
      checkOutput("rnd_wdata", wdata, mExWd);
      checkOutput("rnd_stall", stall, mStall);
      checkOutput("rnd_exmem_wa", xmWa, mExWa);
      checkOutput("rnd_exmem_wb", xmWb, mExWb);
      checkOutput("rnd_exmem_alu", xmAlu, mExAlu);
      checkOutput("rnd_memwb_wa", mwWa, mWbWa);
      checkOutput("rnd_memwb_wb", mwWb, mWbRw);
      checkOutput("rnd_memwb_data", mwData, mWbData);
      if (!mStall) begin
        mWbWa   = mExWa;
        mWbRw   = mExWb[0];
        mWbData = mExWb[1] ? rdata : mExAlu;
        mExWa   = exWa;
        mExWb   = exWb;
        mExRd   = exRd;
        mExWr   = exWr;
        mExAlu  = exAlu;
        mExWd   = exWd;
        streak  = 0;
      end else begin
        streak++;
      end
      nextCycle();
    end

`ifdef MEM_STAGE_WDT_EN
    $display("[TB] watchdog with no ack");
    resetDut();
    applyStimulus(5'd13, 2'b11, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(5'd0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h12345678);
    stallCnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!stall) break;
      stallCnt++;
      checkOutput("wdt_err_low", err, 0);
      nextCycle();
    end
    // One IDLE cycle with the request up, then 255 WAIT cycles.
    checkOutput("wdt_stall_cycles", stallCnt, 256);
    checkOutput("wdt_err", err, 1);
    checkOutput("wdt_req_dropped", req, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("wdt_memwb_zero", mwData, 0);
    checkOutput("wdt_memwb_wb", mwWb, 1);
    checkOutput("wdt_memwb_wa", mwWa, 13);
    checkOutput("wdt_err_sticky", err, 1);
    nextCycle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
